// File: rtl/lvm16_pkg.sv
// ============================================================================
//  Module   : lvm16_pkg
//  Brief    : Shared widths, op-codes and FSM state type for the 16-bit logic unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lvm16_pkg;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage : lvm16_pkg

`default_nettype wire

// File: rtl/lvm16_gates.sv
// ============================================================================
//  Module   : lvm16_and / lvm16_or / lvm16_xor / lvm16_not
//  Brief    : 16-bit bitwise gate primitives used by the logic-unit datapath.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lvm16_and #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = a_i & b_i;
endmodule : lvm16_and

module lvm16_or #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = a_i | b_i;
endmodule : lvm16_or

module lvm16_xor #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = a_i ^ b_i;
endmodule : lvm16_xor

module lvm16_not #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = ~a_i;
endmodule : lvm16_not

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
//  Module   : rr_pick4
//  Brief    : Combinational 4-way round-robin picker starting the search at ptr.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick4 (
  input  logic [3:0] valid_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] grant_o,
  output logic       any_valid_o
);

  logic [1:0] idx;

  // Walk farthest-first so the candidate nearest to ptr is written last and wins.
  always_comb begin
    grant_o     = 2'd0;
    any_valid_o = 1'b0;
    idx         = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_i + 2'(k);
      if (valid_i[idx]) begin
        grant_o     = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule : rr_pick4

`default_nettype wire

// File: rtl/lu_arbiter.sv
// ============================================================================
//  Module   : lu_arbiter
//  Brief    : Round-robin arbiter for 4 requesters sharing one registered 16-bit logic unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lu_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [2*NREQ-1:0]     req_op_i,
  input  logic [WIDTH*NREQ-1:0] req_a_i,
  input  logic [WIDTH*NREQ-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic [1:0]            rsp_id_o,
  output logic                  busy_o
);

  import lvm16_pkg::*;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [1:0]       rsp_id_q;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [1:0]       op_arr [NREQ];

  logic [1:0]       grant;
  logic             any_valid;
  logic             win;
  logic             xfer;
  logic [WIDTH-1:0] opa, opb;
  logic [1:0]       op;
  logic [WIDTH-1:0] y_and, y_or, y_xor, y_not, res_d;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = req_a_i[gi*WIDTH +: WIDTH];
    assign b_arr[gi]  = req_b_i[gi*WIDTH +: WIDTH];
    assign op_arr[gi] = req_op_i[gi*2 +: 2];
  end

  rr_pick4 u_pick (
    .valid_i     (req_valid_i),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  // Accept window: empty slot, or the held result leaves in this same cycle.
  assign win  = rst_ni && ((state_q == ST_IDLE) || rsp_ready_i);
  assign xfer = win && any_valid;

  assign req_ready_o = xfer ? (NREQ'(1) << grant) : '0;

  assign opa = a_arr[grant];
  assign opb = b_arr[grant];
  assign op  = op_arr[grant];

  lvm16_and #(.WIDTH(WIDTH)) u_and (.a_i(opa), .b_i(opb), .y_o(y_and));
  lvm16_or  #(.WIDTH(WIDTH)) u_or  (.a_i(opa), .b_i(opb), .y_o(y_or));
  lvm16_xor #(.WIDTH(WIDTH)) u_xor (.a_i(opa), .b_i(opb), .y_o(y_xor));
  lvm16_not #(.WIDTH(WIDTH)) u_not (.a_i(opa), .y_o(y_not));

  always_comb begin
    res_d = y_and;
    case (op)
      OP_AND:  res_d = y_and;
      OP_OR:   res_d = y_or;
      OP_XOR:  res_d = y_xor;
      OP_NOT:  res_d = y_not;
      default: res_d = y_and;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            state_q     <= ST_HOLD;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= res_d;
            rsp_id_q    <= grant;
            ptr_q       <= grant + 2'd1;
          end
        end
        ST_HOLD: begin
          if (xfer) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= res_d;
            rsp_id_q    <= grant;
            ptr_q       <= grant + 2'd1;
          end else if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_o      = rst_ni && (state_q == ST_HOLD);

endmodule : lu_arbiter

`default_nettype wire

// File: tb/tb_lu_arbiter.sv
// ============================================================================
//  Module   : tb_lu_arbiter
//  Brief    : Directed self-checking bench for lu_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lu_arbiter #(.WIDTH(16), .NREQ(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    req_op[2*i +: 2] = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  logic [1:0]  exp_ops  [4];
  logic [15:0] exp_res  [4];
  int          exp_gnt  [5];

  initial begin
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    tick(); tick();
    // Reset state, requests must be refused while reset is asserted
    chk("rst_ready", {12'd0, req_ready}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'h0000);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_id", {14'd0, rsp_id}, 16'h0000);

    // Single OR op from requester 0
    rst_n = 1'b1; req_valid = 4'b0000;
    tick();
    set_req(0, 2'b01, 16'h0000, 16'hFFFF);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", {12'd0, req_ready}, 16'h0001);
    tick();
    req_valid = 4'b0000;
    chk("single_valid", {15'd0, rsp_valid}, 16'h0001);
    chk("single_data", rsp_data, 16'hFFFF);
    chk("single_id", {14'd0, rsp_id}, 16'h0000);
    chk("single_busy", {15'd0, busy}, 16'h0001);
    rsp_ready = 1'b1;
    tick();
    chk("drain_valid", {15'd0, rsp_valid}, 16'h0000);
    chk("drain_data_kept", rsp_data, 16'hFFFF);
    chk("drain_busy", {15'd0, busy}, 16'h0000);

    // All four ops back-to-back on requester 1 (ptr=1 now)
    exp_ops = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_res = '{16'h0F00, 16'hFFF0, 16'hF0F0, 16'h00FF};
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_req(1, exp_ops[k], 16'hFF00, 16'h0FF0);
      #1;
      chk("ops_ready", {12'd0, req_ready}, 16'h0002);
      tick();
      chk("ops_data", rsp_data, exp_res[k]);
      chk("ops_id", {14'd0, rsp_id}, 16'h0001);
    end
    req_valid = 4'b0000;
    tick();
    chk("ops_idle", {15'd0, rsp_valid}, 16'h0000);

    // Backpressure: req2 XOR result held while req3 waits (ptr=2)
    set_req(2, 2'b10, 16'h1234, 16'h00FF);
    req_valid = 4'b0100;
    tick();
    chk("bp_first_data", rsp_data, 16'h12CB);
    set_req(3, 2'b11, 16'hAAAA, 16'h1234);
    req_valid = 4'b1000; rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready_blocked", {12'd0, req_ready}, 16'h0000);
      chk("bp_data_stable", rsp_data, 16'h12CB);
      chk("bp_id_stable", {14'd0, rsp_id}, 16'h0002);
      chk("bp_valid_held", {15'd0, rsp_valid}, 16'h0001);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {12'd0, req_ready}, 16'h0008);
    tick();
    chk("bp_next_data", rsp_data, 16'h5555);
    chk("bp_next_id", {14'd0, rsp_id}, 16'h0003);

    // One more transfer so ptr=1, then reset in HOLD
    set_req(0, 2'b00, 16'hF0F0, 16'hFFFF);
    req_valid = 4'b0001;
    tick();
    chk("pre_rst_data", rsp_data, 16'hF0F0);
    req_valid = 4'b0000; rst_n = 1'b0;
    tick();
    chk("midrst_valid", {15'd0, rsp_valid}, 16'h0000);
    chk("midrst_data", rsp_data, 16'h0000);
    chk("midrst_id", {14'd0, rsp_id}, 16'h0000);
    chk("midrst_busy", {15'd0, busy}, 16'h0000);

    // Fairness after reset: all valid, XOR with B=0 returns A
    rst_n = 1'b1;
    set_req(0, 2'b10, 16'h1111, 16'h0000);
    set_req(1, 2'b10, 16'h2222, 16'h0000);
    set_req(2, 2'b10, 16'h3333, 16'h0000);
    set_req(3, 2'b10, 16'h4444, 16'h0000);
    exp_gnt = '{0, 1, 2, 3, 0};
    exp_res = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", {12'd0, req_ready}, 16'(4'b0001 << exp_gnt[k]));
      tick();
      chk("rr_valid", {15'd0, rsp_valid}, 16'h0001);
      chk("rr_id", {14'd0, rsp_id}, 16'(exp_gnt[k]));
      chk("rr_data", rsp_data, exp_res[exp_gnt[k]]);
    end

    // Withdrawal: ptr=1, req1 granted, req2 drops, req3 must follow
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b1110;
    #1;
    chk("wd_first_ready", {12'd0, req_ready}, 16'h0002);
    tick();
    chk("wd_first_id", {14'd0, rsp_id}, 16'h0001);
    req_valid = 4'b1010;
    #1;
    chk("wd_skip_ready", {12'd0, req_ready}, 16'h0008);
    tick();
    chk("wd_skip_id", {14'd0, rsp_id}, 16'h0003);
    chk("wd_skip_data", rsp_data, 16'h4444);
    req_valid = 4'b0000;
    tick();
    chk("wd_end_valid", {15'd0, rsp_valid}, 16'h0000);
    chk("wd_end_data_kept", rsp_data, 16'h4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lu_arbiter

`default_nettype wire

// File: doc/lu_arbiter.md
LU_ARBITER -- requirements
Module: lu_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; only 16 is supported.
REQ-002 Parameter: NREQ, 4, number of requesters; fixed at 4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 req_valid  input  4  per-requester request valid.
REQ-006 req_ready  output  4  per-requester accept; at most one bit high in any cycle.
REQ-007 req_op  input  8  2-bit op per requester; requester i uses bits [2i+1:2i].
REQ-008 req_a  input  64  operand A per requester; requester i uses bits [16i+15:16i].
REQ-009 req_b  input  64  operand B per requester, same packing as req_a.
REQ-010 rsp_valid  output  1  registered result valid.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_data  output  16  registered result.
REQ-013 rsp_id  output  2  index of the requester that owns rsp_data.
REQ-014 busy  output  1  high while a result is held (state HOLD).

Function
REQ-015 Op encoding: 00 = A AND B, 01 = A OR B, 10 = A XOR B, 11 = NOT A (B ignored); bitwise over all 16 bits, no carries or flags.
REQ-016 FSM states: IDLE (no result held) and HOLD (result held, rsp_valid=1).
REQ-017 Accept window = (state==IDLE) or (state==HOLD and rsp_ready==1).
REQ-018 Inside the accept window, grant g = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod 4; req_ready[g]=1 combinationally, all other bits 0.
REQ-019 Outside the accept window, or with no req_valid bit set, req_ready = 0000.
REQ-020 Transfer = req_valid[g] and req_ready[g]; on a transfer the op result is registered into rsp_data, g into rsp_id, state goes to HOLD, ptr becomes (g+1) mod 4.
REQ-021 Latency: a transfer in cycle N gives rsp_valid=1 with the valid result in cycle N+1.
REQ-022 In HOLD, rsp_data and rsp_id stay stable until rsp_ready=1.
REQ-023 HOLD with rsp_ready=1 and a transfer in the same cycle: the result is replaced and the block stays in HOLD (back-to-back, one result per cycle).
REQ-024 HOLD with rsp_ready=1 and no transfer: state goes to IDLE and rsp_valid drops the next cycle; rsp_data keeps its last value.
REQ-025 ptr changes only on a transfer.
REQ-026 Fairness: a requester that holds req_valid continuously is granted within 4 transfers.
REQ-027 Grant is recomputed every cycle and is not locked; a requester that drops req_valid before its handshake is skipped without error.

Reset
REQ-028 While rst_n=0 at a clock edge: state=IDLE, ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0.
REQ-029 While rst_n=0, req_ready=0000 and busy=0.
REQ-030 Reset during HOLD discards the held result; no response is emitted for it.
REQ-031 First grant after reset release searches from requester 0.

Structure
REQ-032 Shared package lvm16_pkg holds WIDTH, NREQ and the four op-code constants.
REQ-033 Sub-module rr_pick4: combinational round-robin picker, inputs valid[3:0] and ptr[1:0], outputs grant index and any_valid.
REQ-034 The op datapath is built from the existing 16-bit bitwise gate modules, followed by a 4:1 op mux.

Verification
REQ-035 Single op: reset, then req 0 valid, op 01, A=0000, B=FFFF -> req_ready[0]=1 that cycle; next cycle rsp_valid=1, rsp_data=FFFF, rsp_id=0.
REQ-036 All four ops on A=FF00, B=0FF0 -> responses 0F00, FFF0, F0F0, 00FF in order.
REQ-037 All 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0; one result per cycle; no cycle with two req_ready bits set.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles in HOLD -> rsp_data/rsp_id stable, req_ready=0000; rsp_ready=1 -> pending request accepted that same cycle.
REQ-039 Reset mid-HOLD: rst_n=0 for 1 cycle -> rsp_valid=0, rsp_data=0, ptr=0; next grant goes to the lowest valid index.
REQ-040 Request withdrawal: req 2 drops valid before its grant -> req 3 is granted, and no response carries rsp_id=2.
